// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side bundle for mem_arbiter. NREQ follows MEM_ARB_LOADER_EN
// (3 with the boot loader, else 2); slot i of addr/wdata sits at [i*W +: W].
interface mem_arbiter_if #(
`ifdef MEM_ARB_LOADER_EN
    parameter int NREQ   = 3,
`else
    parameter int NREQ   = 2,
`endif
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   ram_enable;
    logic                   ram_read;
    logic                   ram_write;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_din;
    logic [DATA_W-1:0]      ram_dout;

    // slave: the arbiter itself; master: requesters plus the RAM
    modport slave (
        input  req, we, addr, wdata, ram_dout,
        output gnt, done, rdata, busy,
        output ram_enable, ram_read, ram_write, ram_addr, ram_din
    );

    modport master (
        output req, we, addr, wdata, ram_dout,
        input  gnt, done, rdata, busy,
        input  ram_enable, ram_read, ram_write, ram_addr, ram_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin single-port RAM arbiter and access sequencer (CPU, DMA, optional loader).
// Define MEM_ARB_LOADER_EN to add requester 2 (boot loader) with absolute priority.
module mem_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
`ifdef MEM_ARB_LOADER_EN
    localparam int NREQ = 3;
`else
    localparam int NREQ = 2;
`endif
    localparam int IDX_W = $clog2(NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  winner_reg;
    logic [IDX_W-1:0]  last_winner_reg;
    logic [ADDR_W-1:0] addr_l_reg;
    logic [DATA_W-1:0] wdata_l_reg;
    logic              we_l_reg;
    logic [2:0]        cnt_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [ADDR_W-1:0] slot_addr  [NREQ];
    logic [DATA_W-1:0] slot_wdata [NREQ];

    logic [IDX_W-1:0]  base;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  pick;
    logic              found;
    logic              any_req;
    logic              rr_update;
    logic              arbitrate;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        assign slot_addr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
        assign slot_wdata[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end

`ifdef MEM_ARB_LOADER_EN
    assign rr_update = (winner_reg != LAST_IDX);
`else
    assign rr_update = 1'b1;
`endif

    assign any_req   = |bus.req;
    assign arbitrate = (state_reg == IDLE) || (state_reg == DONE);

    // In DONE the pointer update is still in flight, so search from the current winner
    always_comb begin
        base  = ((state_reg == DONE) && rr_update) ? winner_reg : last_winner_reg;
        pick  = base;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(base) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
`ifdef MEM_ARB_LOADER_EN
        if (bus.req[NREQ-1]) begin
            pick = LAST_IDX;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: state_next = any_req ? GRANT : IDLE;
            GRANT:      state_next = we_l_reg ? DONE : WAIT;
            WAIT:       state_next = (cnt_reg == 3'd1) ? DONE : WAIT;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt        = '0;
        bus.done       = '0;
        bus.busy       = (state_reg != IDLE);
        bus.ram_enable = 1'b0;
        bus.ram_read   = 1'b0;
        bus.ram_write  = 1'b0;
        bus.ram_addr   = addr_l_reg;
        bus.ram_din    = wdata_l_reg;
        bus.rdata      = rdata_reg;
        case (state_reg)
            GRANT: begin
                bus.gnt        = NREQ'(1) << winner_reg;
                bus.ram_enable = 1'b1;
                bus.ram_read   = ~we_l_reg;
                bus.ram_write  = we_l_reg;
            end
            WAIT: begin
                bus.ram_enable = 1'b1;
                bus.ram_read   = 1'b1;
            end
            DONE: bus.done = NREQ'(1) << winner_reg;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            winner_reg      <= '0;
            last_winner_reg <= LAST_IDX;
            addr_l_reg      <= '0;
            wdata_l_reg     <= '0;
            we_l_reg        <= 1'b0;
            cnt_reg         <= '0;
            rdata_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (arbitrate && any_req) begin
                winner_reg  <= pick;
                addr_l_reg  <= slot_addr[pick];
                wdata_l_reg <= slot_wdata[pick];
                we_l_reg    <= bus.we[pick];
            end
            if ((state_reg == DONE) && rr_update) begin
                last_winner_reg <= winner_reg;
            end
            if ((state_reg == GRANT) && !we_l_reg) begin
                cnt_reg <= 3'(RD_LAT);
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - 3'd1;
                if (cnt_reg == 3'd1) begin
                    rdata_reg <= bus.ram_dout;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM of latency RD_LAT.
// Unused RAM pipeline slots read back as BAD0BAD0 so early or late capture shows up.
module tb_mem_arbiter;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;
`ifdef MEM_ARB_LOADER_EN
    localparam int NREQ = 3;
`else
    localparam int NREQ = 2;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model
    logic [DATA_W-1:0] mem    [512];
    logic [DATA_W-1:0] pipe_d [RD_LAT];
    logic              pipe_v [RD_LAT];

    always @(posedge clk) begin
        if (bus.ram_enable && bus.ram_write) mem[bus.ram_addr] <= bus.ram_din;
        pipe_d[0] <= mem[bus.ram_addr];
        pipe_v[0] <= bus.ram_enable && bus.ram_read;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
    end
    assign bus.ram_dout = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_slot(input int i, input logic r, input logic w,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.req[i]                   = r;
        bus.we[i]                    = w;
        bus.addr[i*ADDR_W +: ADDR_W] = a;
        bus.wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic apply_reset();
        bus.req = '0;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_write(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        set_slot(i, 1'b1, 1'b1, a, d);
        step();
        check("wr_gnt", 64'(bus.gnt), 64'(onehot(i)));
        check("wr_strobe", 64'({bus.ram_enable, bus.ram_read, bus.ram_write}), 64'(3'b101));
        check("wr_addr", 64'(bus.ram_addr), 64'(a));
        check("wr_din", 64'(bus.ram_din), 64'(d));
        bus.req[i] = 1'b0;
        step();
        check("wr_done", 64'(bus.done), 64'(onehot(i)));
        check("wr_done_idle_ram", 64'(bus.ram_enable), 64'(0));
        $display("write req%0d addr=%03h data=%08h", i, a, d);
    endtask

    task automatic do_read(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        logic [DATA_W-1:0] prev;
        prev = bus.rdata;
        set_slot(i, 1'b1, 1'b0, a, '0);
        step();
        check("rd_gnt", 64'(bus.gnt), 64'(onehot(i)));
        check("rd_strobe", 64'({bus.ram_enable, bus.ram_read, bus.ram_write}), 64'(3'b110));
        check("rd_addr", 64'(bus.ram_addr), 64'(a));
        bus.req[i] = 1'b0;
        for (int c = 0; c < RD_LAT; c++) begin
            step();
            check("rd_wait_read", 64'(bus.ram_read), 64'(1));
            check("rd_wait_done", 64'(bus.done), 64'(0));
        end
        check("rd_rdata_hold", 64'(bus.rdata), 64'(prev));
        step();
        check("rd_done", 64'(bus.done), 64'(onehot(i)));
        check("rd_rdata", 64'(bus.rdata), 64'(exp));
        $display("read  req%0d addr=%03h data=%08h", i, a, bus.rdata);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        step();
        step();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_gnt", 64'(bus.gnt), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_rdata", 64'(bus.rdata), 64'(0));
        check("rst_ram_ctl", 64'({bus.ram_enable, bus.ram_read, bus.ram_write}), 64'(0));
        check("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
        check("rst_ram_din", 64'(bus.ram_din), 64'(0));
        reset = 1'b0;
        step();

        do_write(0, 9'h005, 32'hDEAD_BEEF);
        do_read(0, 9'h005, 32'hDEAD_BEEF);
        do_write(1, 9'h1FF, 32'h1357_9BDF);
        check("rdata_after_write", 64'(bus.rdata), 64'(32'hDEAD_BEEF));
        do_read(0, 9'h1FF, 32'h1357_9BDF);
        do_read(1, 9'h005, 32'hDEAD_BEEF);
        step();
        check("idle_busy", 64'(bus.busy), 64'(0));

        // CPU and DMA held together from reset: grants alternate, no bubble
        apply_reset();
        set_slot(0, 1'b1, 1'b1, 9'h020, 32'h0000_0A0A);
        set_slot(1, 1'b1, 1'b1, 9'h021, 32'h0000_0B0B);
        for (int c = 1; c <= 8; c++) begin
            logic [NREQ-1:0] eg, ed;
            step();
            eg = '0;
            ed = '0;
            case (c)
                1, 5: eg = onehot(0);
                3, 7: eg = onehot(1);
                2, 6: ed = onehot(0);
                default: ed = onehot(1);
            endcase
            check($sformatf("rr_gnt_c%0d", c), 64'(bus.gnt), 64'(eg));
            check($sformatf("rr_done_c%0d", c), 64'(bus.done), 64'(ed));
            $display("rr cycle %0d gnt=%b done=%b", c, bus.gnt, bus.done);
            if (c == 7) bus.req = '0;
        end
        step();
        check("rr_end_busy", 64'(bus.busy), 64'(0));

        // Reset during the WAIT of a read
        do_read(0, 9'h005, 32'hDEAD_BEEF);
        set_slot(0, 1'b1, 1'b0, 9'h1FF, '0);
        step();
        bus.req[0] = 1'b0;
        step();
        check("abort_in_wait", 64'(bus.ram_read), 64'(1));
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_rdata", 64'(bus.rdata), 64'(0));
        check("abort_ram_en", 64'(bus.ram_enable), 64'(0));
        step();
        reset = 1'b0;
        $display("reset during read wait");
        set_slot(0, 1'b1, 1'b1, 9'h010, 32'h0000_0010);
        set_slot(1, 1'b1, 1'b1, 9'h011, 32'h0000_0011);
        step();
        check("post_rst_gnt", 64'(bus.gnt), 64'(onehot(0)));
        bus.req = '0;
        step();
        check("post_rst_done", 64'(bus.done), 64'(onehot(0)));
        step();
        check("withdrawn_busy", 64'(bus.busy), 64'(0));
        check("withdrawn_gnt", 64'(bus.gnt), 64'(0));
        do_read(1, 9'h010, 32'h0000_0010);

`ifdef MEM_ARB_LOADER_EN
        apply_reset();
        set_slot(0, 1'b1, 1'b1, 9'h030, 32'h0000_0030);
        set_slot(1, 1'b1, 1'b1, 9'h031, 32'h0000_0031);
        set_slot(2, 1'b1, 1'b1, 9'h032, 32'h0000_0032);
        for (int c = 1; c <= 8; c++) begin
            logic [NREQ-1:0] eg, ed;
            step();
            eg = '0;
            ed = '0;
            case (c)
                1, 3: eg = onehot(2);
                2, 4: ed = onehot(2);
                5:    eg = onehot(0);
                6:    ed = onehot(0);
                7:    eg = onehot(1);
                default: ed = onehot(1);
            endcase
            check($sformatf("ldr_gnt_c%0d", c), 64'(bus.gnt), 64'(eg));
            check($sformatf("ldr_done_c%0d", c), 64'(bus.done), 64'(ed));
            $display("loader cycle %0d gnt=%b done=%b", c, bus.gnt, bus.done);
            if (c == 3) bus.req[2] = 1'b0;
            if (c == 7) bus.req = '0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
